// File: rtl/dual_issue_ctrl_pkg.sv
// Shared types and constants for the dual-issue controller.
// `D_WIDTH sizes the optional perf counters (enabled by DUAL_ISSUE_PERF_EN).
`ifndef D_WIDTH
`define D_WIDTH 8
`endif

package dual_issue_ctrl_pkg;
  localparam int RA_W_DEF  = 5;
  localparam int NUM_SLOTS = 2;

  typedef enum logic {
    ST_PAIR  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  typedef struct packed {
    logic stall_f;
    logic stall1;
    logic stall2;
    logic flush1;
    logic flush2;
    logic flush_e;
    logic issue1;
    logic issue2;
  } ctrl_t;
endpackage

// File: rtl/dual_hazard_det.sv
// Combinational hazard detection for the decode pair: intra-pair raw/waw/mem
// conflicts and load-use against the two EX slots.
module dual_hazard_det
  import dual_issue_ctrl_pkg::*;
#(
  parameter int              RA_W     = RA_W_DEF,
  parameter logic [RA_W-1:0] ZERO_REG = '0
) (
  input  logic [NUM_SLOTS-1:0]           valid,
  input  logic [NUM_SLOTS-1:0]           reg_write,
  input  logic [NUM_SLOTS-1:0]           mem,
  input  logic [NUM_SLOTS-1:0][RA_W-1:0] rs1,
  input  logic [NUM_SLOTS-1:0][RA_W-1:0] rs2,
  input  logic [NUM_SLOTS-1:0][RA_W-1:0] rd,
  input  logic [NUM_SLOTS-1:0]           mem_read_e,
  input  logic [NUM_SLOTS-1:0][RA_W-1:0] rd_e,
  input  logic                           in_split,
  output logic                           raw,
  output logic                           waw,
  output logic                           mem2,
  output logic                           lu
);
  logic                 both;
  logic [NUM_SLOTS-1:0] lu_slot;

  // Intra-pair hazards only exist when both slots hold real instructions.
  assign both = valid[0] & valid[1];
  assign raw  = both & reg_write[0] & (rd[0] != ZERO_REG) &
                ((rd[0] == rs1[1]) | (rd[0] == rs2[1]));
  assign waw  = both & reg_write[0] & reg_write[1] & (rd[0] != ZERO_REG) &
                (rd[0] == rd[1]);
  assign mem2 = both & mem[0] & mem[1];

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    logic [NUM_SLOTS-1:0] hit;
    for (genvar e = 0; e < NUM_SLOTS; e++) begin : g_ex
      assign hit[e] = mem_read_e[e] & (rd_e[e] != ZERO_REG) &
                      ((rd_e[e] == rs1[s]) | (rd_e[e] == rs2[s]));
    end
    assign lu_slot[s] = valid[s] & (|hit);
  end

  // Slot 1 has already issued while SPLIT, so only the held slot 2 matters.
  assign lu = lu_slot[1] | (lu_slot[0] & ~in_split);
endmodule

// File: rtl/dual_issue_ctrl.sv
// Issue/hazard controller for the two-slot decode register: pair, split, stall or redirect.
// Define DUAL_ISSUE_PERF_EN to add saturating split / load-use counters.
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int              RA_W     = RA_W_DEF,
  parameter logic [RA_W-1:0] ZERO_REG = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_Valid1D,
  input  logic            i_Valid2D,
  input  logic [RA_W-1:0] i_Rs1_1,
  input  logic [RA_W-1:0] i_Rs2_1,
  input  logic [RA_W-1:0] i_Rd_1,
  input  logic            i_RegWrite1,
  input  logic            i_Mem1,
  input  logic            i_Br1,
  input  logic [RA_W-1:0] i_Rs1_2,
  input  logic [RA_W-1:0] i_Rs2_2,
  input  logic [RA_W-1:0] i_Rd_2,
  input  logic            i_RegWrite2,
  input  logic            i_Mem2,
  input  logic            i_Br2,
  input  logic            i_MemReadE1,
  input  logic            i_MemReadE2,
  input  logic [RA_W-1:0] i_RdE1,
  input  logic [RA_W-1:0] i_RdE2,
  input  logic            i_BranchTakenE,
  output logic            o_StallF,
  output logic            o_Stall1D,
  output logic            o_Stall2D,
  output logic            o_Flush1D,
  output logic            o_Flush2D,
  output logic            o_FlushE,
  output logic            o_Issue1,
  output logic            o_Issue2,
  output logic            o_State
`ifdef DUAL_ISSUE_PERF_EN
  ,
  output logic [`D_WIDTH-1:0] o_SplitCnt,
  output logic [`D_WIDTH-1:0] o_LuCnt
`endif
);
  state_e state, state_nxt;
  ctrl_t  ctrl;
  logic   raw, waw, mem2, lu, split;
  logic   br1_unused;

  dual_hazard_det #(.RA_W(RA_W), .ZERO_REG(ZERO_REG)) u_haz (
    .valid      ({i_Valid2D,   i_Valid1D}),
    .reg_write  ({i_RegWrite2, i_RegWrite1}),
    .mem        ({i_Mem2,      i_Mem1}),
    .rs1        ({i_Rs1_2,     i_Rs1_1}),
    .rs2        ({i_Rs2_2,     i_Rs2_1}),
    .rd         ({i_Rd_2,      i_Rd_1}),
    .mem_read_e ({i_MemReadE2, i_MemReadE1}),
    .rd_e       ({i_RdE2,      i_RdE1}),
    .in_split   (state == ST_SPLIT),
    .raw        (raw),
    .waw        (waw),
    .mem2       (mem2),
    .lu         (lu)
  );

  // A branch in slot 1 must resolve before its neighbour; a slot-2 branch is harmless.
  assign split      = raw | waw | mem2 | (i_Valid1D & i_Valid2D & i_Br1);
  assign br1_unused = i_Br2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_PAIR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_BranchTakenE)                  state_nxt = ST_PAIR;
    else if (lu)                         state_nxt = state;
    else if (state == ST_PAIR && split)  state_nxt = ST_SPLIT;
    else if (state == ST_SPLIT)          state_nxt = ST_PAIR;
  end

  always_comb begin
    ctrl = '0;
    if (i_BranchTakenE) begin
      ctrl.flush1 = 1'b1;
      ctrl.flush2 = 1'b1;
    end else if (lu) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall1  = 1'b1;
      ctrl.stall2  = 1'b1;
      ctrl.flush_e = 1'b1;
    end else if (state == ST_PAIR && split) begin
      // Slot 1 goes now; slot 2 is held and re-presented next cycle.
      ctrl.issue1  = 1'b1;
      ctrl.flush1  = 1'b1;
      ctrl.stall2  = 1'b1;
      ctrl.stall_f = 1'b1;
    end else if (state == ST_PAIR) begin
      ctrl.issue1 = i_Valid1D;
      ctrl.issue2 = i_Valid2D;
    end else begin
      ctrl.issue2 = i_Valid2D;
    end
  end

  assign o_StallF  = ctrl.stall_f;
  assign o_Stall1D = ctrl.stall1;
  assign o_Stall2D = ctrl.stall2;
  assign o_Flush1D = ctrl.flush1;
  assign o_Flush2D = ctrl.flush2;
  assign o_FlushE  = ctrl.flush_e;
  assign o_Issue1  = ctrl.issue1;
  assign o_Issue2  = ctrl.issue2;
  assign o_State   = state;

`ifdef DUAL_ISSUE_PERF_EN
  localparam logic [`D_WIDTH-1:0] CNT_ONE = 1;
  logic [`D_WIDTH-1:0] split_cnt, lu_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_cnt <= '0;
      lu_cnt    <= '0;
    end else begin
      if (state == ST_PAIR && state_nxt == ST_SPLIT && !(&split_cnt))
        split_cnt <= split_cnt + CNT_ONE;
      if (!i_BranchTakenE && lu && !(&lu_cnt))
        lu_cnt <= lu_cnt + CNT_ONE;
    end
  end

  assign o_SplitCnt = split_cnt;
  assign o_LuCnt    = lu_cnt;
`endif
endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed table-driven bench for dual_issue_ctrl plus reset-mid-SPLIT and counter sequences.
`ifndef D_WIDTH
`define D_WIDTH 8
`endif
module tb_dual_issue_ctrl;
  typedef struct packed {
    logic v; logic [4:0] rs1, rs2, rd; logic rw, mem, br;
  } slot_t;
  typedef struct packed {
    slot_t s1, s2; logic ld1; logic [4:0] rde1; logic ld2; logic [4:0] rde2; logic bt;
  } in_t;
  // {state, StallF, Stall1D, Stall2D, Flush1D, Flush2D, FlushE, Issue1, Issue2}
  typedef struct { in_t i; logic [8:0] e; } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  in_t  cur = '0;
  logic o_StallF, o_Stall1D, o_Stall2D, o_Flush1D, o_Flush2D, o_FlushE, o_Issue1, o_Issue2, o_State;
`ifdef DUAL_ISSUE_PERF_EN
  logic [`D_WIDTH-1:0] o_SplitCnt, o_LuCnt;
`endif
  int checks = 0, errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  dual_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_Valid1D(cur.s1.v), .i_Valid2D(cur.s2.v),
    .i_Rs1_1(cur.s1.rs1), .i_Rs2_1(cur.s1.rs2), .i_Rd_1(cur.s1.rd),
    .i_RegWrite1(cur.s1.rw), .i_Mem1(cur.s1.mem), .i_Br1(cur.s1.br),
    .i_Rs1_2(cur.s2.rs1), .i_Rs2_2(cur.s2.rs2), .i_Rd_2(cur.s2.rd),
    .i_RegWrite2(cur.s2.rw), .i_Mem2(cur.s2.mem), .i_Br2(cur.s2.br),
    .i_MemReadE1(cur.ld1), .i_MemReadE2(cur.ld2), .i_RdE1(cur.rde1), .i_RdE2(cur.rde2),
    .i_BranchTakenE(cur.bt),
    .o_StallF(o_StallF), .o_Stall1D(o_Stall1D), .o_Stall2D(o_Stall2D),
    .o_Flush1D(o_Flush1D), .o_Flush2D(o_Flush2D), .o_FlushE(o_FlushE),
    .o_Issue1(o_Issue1), .o_Issue2(o_Issue2), .o_State(o_State)
`ifdef DUAL_ISSUE_PERF_EN
    , .o_SplitCnt(o_SplitCnt), .o_LuCnt(o_LuCnt)
`endif
  );

  function automatic slot_t sl(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                               logic rw, logic mem, logic br);
    sl = '{v, rs1, rs2, rd, rw, mem, br};
  endfunction

  function automatic in_t mk(slot_t a, slot_t b, logic ld1, logic [4:0] r1,
                             logic ld2, logic [4:0] r2, logic bt);
    mk = '{a, b, ld1, r1, ld2, r2, bt};
  endfunction

  task automatic add(in_t i, logic [8:0] e);
    vec_t t;
    t.i = i; t.e = e;
    vecs.push_back(t);
  endtask

  function automatic logic [8:0] outs();
    outs = {o_State, o_StallF, o_Stall1D, o_Stall2D, o_Flush1D, o_Flush2D, o_FlushE, o_Issue1, o_Issue2};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    slot_t z, ind1, ind2, raw1, raw2;
    in_t   idle, pair_ind, pair_raw, hold;
    z        = '0;
    ind1     = sl(1, 5'd2, 5'd3, 5'd1, 1, 0, 0);
    ind2     = sl(1, 5'd2, 5'd3, 5'd4, 1, 0, 0);
    raw1     = sl(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    raw2     = sl(1, 5'd5, 5'd3, 5'd6, 1, 0, 0);
    idle     = '0;
    pair_ind = mk(ind1, ind2, 0, 0, 0, 0, 0);
    pair_raw = mk(raw1, raw2, 0, 0, 0, 0, 0);
    hold     = mk(z, raw2, 0, 0, 0, 0, 0);

    add(idle,     9'b0_000_000_00);
    add(pair_ind, 9'b0_000_000_11);
    add(pair_raw, 9'b0_101_100_10);  // RAW r5 -> split
    add(hold,     9'b1_000_000_01);
    add(pair_ind, 9'b0_000_000_11);
    add(mk(ind1, sl(1, 5'd2, 5'd7, 5'd4, 1, 0, 0), 1, 5'd7, 0, 0, 0), 9'b0_111_001_00);
    add(pair_ind, 9'b0_000_000_11);
    add(mk(sl(1, 0, 0, 0, 1, 0, 0), sl(1, 0, 0, 0, 1, 0, 0), 0, 0, 0, 0, 0), 9'b0_000_000_11);
    add(mk(sl(1, 5'd2, 5'd3, 5'd1, 0, 1, 0), sl(1, 5'd8, 5'd9, 5'd4, 0, 1, 0), 0, 0, 0, 0, 0),
        9'b0_101_100_10);           // mem2 -> split
    add(mk(z, sl(1, 5'd7, 5'd3, 5'd4, 1, 0, 0), 0, 0, 1, 5'd7, 1), 9'b1_000_110_00);
    add(idle,     9'b0_000_000_00);
    add(mk(sl(1, 5'd2, 5'd3, 5'd9, 1, 0, 0), sl(1, 5'd4, 5'd6, 5'd9, 1, 0, 0), 0, 0, 0, 0, 0),
        9'b0_101_100_10);           // WAW r9 -> split
    add(mk(z, sl(1, 5'd8, 5'd6, 5'd9, 1, 0, 0), 1, 5'd8, 0, 0, 0), 9'b1_111_001_00);
    add(mk(z, sl(1, 5'd8, 5'd6, 5'd9, 1, 0, 0), 0, 0, 0, 0, 0), 9'b1_000_000_01);
    add(mk(sl(1, 5'd2, 5'd3, 5'd0, 0, 0, 1), ind2, 0, 0, 0, 0, 0), 9'b0_101_100_10);
    add(mk(sl(1, 5'd8, 5'd3, 5'd0, 0, 0, 0), ind2, 1, 5'd8, 0, 0, 0), 9'b1_000_000_01);
    add(mk(raw1, sl(0, 5'd5, 5'd3, 5'd6, 1, 0, 0), 0, 0, 0, 0, 0), 9'b0_000_000_10);
    add(mk(sl(1, 0, 0, 5'd1, 1, 0, 0), sl(1, 0, 0, 5'd4, 1, 0, 0), 1, 5'd0, 1, 5'd0, 0),
        9'b0_000_000_11);           // load to r0 is never a hazard
    add(mk(ind1, ind2, 1, 5'd2, 0, 0, 1), 9'b0_000_110_00);
    add(idle,     9'b0_000_000_00);

    cur = idle;
    #1 chk("reset_outs", outs(), 9'b0_000_000_00);
`ifdef DUAL_ISSUE_PERF_EN
    chk("reset_splitcnt", o_SplitCnt, 0);
    chk("reset_lucnt", o_LuCnt, 0);
`endif
    #2 rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      cur = vecs[k].i;
      #1 chk($sformatf("vec%0d", k), outs(), vecs[k].e);
    end
`ifdef DUAL_ISSUE_PERF_EN
    chk("splitcnt_table", o_SplitCnt, 4);
    chk("lucnt_table", o_LuCnt, 2);
`endif

    // Reset asserted while a split is in progress.
    @(negedge clk); cur = pair_raw;
    @(negedge clk); cur = hold;
    #1 chk("pre_reset_split", o_State, 1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_state", o_State, 0);
`ifdef DUAL_ISSUE_PERF_EN
    chk("mid_reset_splitcnt", o_SplitCnt, 0);
`endif
    @(negedge clk); rst_n = 1'b1; cur = idle;

    for (int n = 0; n < 3; n++) begin
      @(negedge clk); cur = pair_raw;
      #1 chk($sformatf("split%0d_issue", n), outs(), 9'b0_101_100_10);
      @(negedge clk); cur = hold;
      #1 chk($sformatf("split%0d_hold", n), outs(), 9'b1_000_000_01);
    end
    @(negedge clk); cur = idle;
    #1 chk("after_splits_state", o_State, 0);
`ifdef DUAL_ISSUE_PERF_EN
    chk("splitcnt_three", o_SplitCnt, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_issue_ctrl.md
Name: dual_issue_ctrl

Overview:
- Issue/hazard controller for the two-slot fetch/decode pipeline register.
- Each cycle it decides whether the decode pair issues together, splits over two cycles or stalls, and redirects on a taken branch.
- Drives the per-slot stall and flush inputs of the decode-stage register, the fetch stall and the EX bubble.
- Sits beside decode; consumes decoded register fields from decode and load/branch status from EX.

Parameters:
- RA_W, 5, register-address width
- ZERO_REG, 0, hard-wired zero register; never a hazard source

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_Valid1D, i_Valid2D  in  1 each  decode slot holds a real instruction
- i_Rs1_1, i_Rs2_1, i_Rd_1  in  RA_W each  slot-1 sources and destination
- i_RegWrite1, i_Mem1, i_Br1  in  1 each  slot-1 writes register / memory op / branch
- i_Rs1_2, i_Rs2_2, i_Rd_2, i_RegWrite2, i_Mem2, i_Br2  in  same  slot-2 equivalents
- i_MemReadE1, i_MemReadE2  in  1 each  EX slot holds a load
- i_RdE1, i_RdE2  in  RA_W each  EX load destinations
- i_BranchTakenE  in  1  EX redirect
- o_StallF  out  1  hold PC/fetch
- o_Stall1D, o_Stall2D  out  1 each  hold decode slot
- o_Flush1D, o_Flush2D  out  1 each  clear decode slot
- o_FlushE  out  1  insert EX bubble
- o_Issue1, o_Issue2  out  1 each  slot passes to EX this cycle
- o_State  out  1  0=PAIR, 1=SPLIT

Behaviour:
- Reset (async, rst_n low): state PAIR. Registered outputs are 0; with the counter option compiled in, the counters are also 0. Combinational outputs follow from state PAIR and the inputs.
- Outputs are combinational from state and inputs; only the state (and optional counters) is registered.
- Terms (all qualified by valid; a match on ZERO_REG never counts):
  - raw = i_RegWrite1 && i_Rd_1 matches i_Rs1_2 or i_Rs2_2
  - waw = both slots write the same i_Rd
  - mem2 = i_Mem1 && i_Mem2
  - split = raw | waw | mem2 | i_Br1
  - lu = any source in a valid decode slot matches a load destination in EX. In SPLIT only slot 2 is checked.
- Priority, highest first: redirect > load-use > split > normal.
- Redirect (i_BranchTakenE):
  - Outputs: o_Flush1D=1, o_Flush2D=1, o_FlushE=0, o_Issue1=0, o_Issue2=0, all stalls 0.
  - Next state PAIR, from either state.
- Load-use (lu):
  - Outputs: o_StallF=1, o_Stall1D=1, o_Stall2D=1, o_FlushE=1, o_Issue1=0, o_Issue2=0.
  - State unchanged.
  - Repeats each cycle while lu holds.
- PAIR, split:
  - Outputs: o_Issue1=1, o_Issue2=0, o_Flush1D=1, o_Stall2D=1, o_StallF=1.
  - Next state SPLIT.
- PAIR, normal:
  - Outputs: o_Issue1 and o_Issue2 equal the valids; no stall or flush.
  - State stays PAIR.
- SPLIT, normal:
  - Outputs: o_Issue2=1, o_Issue1=0, no stalls.
  - Next state PAIR. Fetch refills both slots.
- Invalid slots never issue and never create a hazard; an empty pair issues nothing.
- o_Flush1D and o_Flush2D are asserted together only on redirect.
- Reset mid-SPLIT: state returns to PAIR immediately; the held slot-2 instruction is discarded by the register reset.

Optional Feature:
- Macro DUAL_ISSUE_PERF_EN.
- When defined, adds outputs o_SplitCnt and o_LuCnt, each `D_WIDTH bits.
  - o_SplitCnt increments on every PAIR->SPLIT transition.
  - o_LuCnt increments on every load-use stall cycle.
  - Both saturate at all-ones and reset to 0.
- When undefined, the ports and logic are absent; control behaviour is identical.

Decomposition:
- param.v holds `D_WIDTH, state encodings ST_PAIR and ST_SPLIT, and the RA_W default.
- One sub-module, dual_hazard_det: purely combinational raw/waw/mem2/lu detection. The FSM and output decode stay in dual_issue_ctrl.

Test Plan:
- Independent pair (slot 1 writes r1, slot 2 reads r2/r3): o_Issue1=o_Issue2=1, no stall; state remains PAIR.
- Slot 1 writes r5, slot 2 reads r5:
  - cycle N: o_Issue1=1, o_Flush1D=1, o_Stall2D=1, o_StallF=1.
  - cycle N+1: state SPLIT, o_Issue2=1.
  - cycle N+2: state PAIR.
- EX load to r7, decode slot 2 reads r7: o_StallF, o_Stall1D, o_Stall2D and o_FlushE all 1 for one cycle; issue resumes next cycle when EX no longer matches.
- i_BranchTakenE asserted in SPLIT together with lu: both flushes 1, no issue, no stall; next state PAIR.
- Both slots write r0 with the same sources: no hazard, dual issue. Both slots memory ops: split, as in the r5 case.
- rst_n pulsed low mid-SPLIT: state 0 asynchronously. With DUAL_ISSUE_PERF_EN, o_SplitCnt=0 after reset and 3 after three splits.
